// File: rtl/bool_eval_pipe.sv
// bool_eval_pipe: evaluates a four-operand boolean function on WIDTH lanes.
// Parallel mode computes all lanes on the acceptance edge. Serial mode walks
// the lanes LSB first, one per edge. In both modes the result is then held
// until the consumer acknowledges it.
module bool_eval_pipe #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             iCLK,
    input  logic             iRST_n,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic [WIDTH-1:0] iC,
    input  logic [WIDTH-1:0] iD,
    input  logic             iValid,
    input  logic             iMode,
    input  logic             iAck,
    output logic             oReady,
    output logic             oBusy,
    output logic             oValid,
    output logic [WIDTH-1:0] oY,
    output logic [CNT_W-1:0] oOnes
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] sh_a_q;
    logic [WIDTH-1:0] sh_b_q;
    logic [WIDTH-1:0] sh_c_q;
    logic [WIDTH-1:0] sh_d_q;
    logic [WIDTH-1:0] y_q;
    logic [CNT_W-1:0] ones_q;
    logic [WIDTH-1:0] par_y;
    logic [CNT_W-1:0] par_ones;
    logic             lane_y;
    logic             accept;

    // Boolean function applied to all lanes at once.
    function automatic logic [WIDTH-1:0] eval_vec(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] c,
        input logic [WIDTH-1:0] d
    );
        eval_vec = ~(b ^ d) | (~(a ^ c) & (~b | d));
    endfunction

    // Number of set bits in a result vector.
    function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + CNT_W'(v[i]);
        end
        popcount = cnt;
    endfunction

    // Parallel result and its count, plus the single lane the serial walk is on.
    always_comb begin
        par_y    = eval_vec(iA, iB, iC, iD);
        par_ones = popcount(par_y);
        lane_y   = ~(sh_b_q[0] ^ sh_d_q[0]) | (~(sh_a_q[0] ^ sh_c_q[0]) & (~sh_b_q[0] | sh_d_q[0]));
        accept   = (state_q == IDLE) && iValid;
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: serial walk ends on the last lane, HOLD waits for ack.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (iValid) begin
                    state_d = iMode ? SHIFT : HOLD;
                end
            end
            SHIFT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (iAck) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: operands are captured only on acceptance, so later input
    // changes cannot disturb the operation; HOLD leaves the result untouched.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            idx_q  <= '0;
            sh_a_q <= '0;
            sh_b_q <= '0;
            sh_c_q <= '0;
            sh_d_q <= '0;
            y_q    <= '0;
            ones_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (!iMode) begin
                            y_q    <= par_y;
                            ones_q <= par_ones;
                        end else begin
                            sh_a_q <= iA;
                            sh_b_q <= iB;
                            sh_c_q <= iC;
                            sh_d_q <= iD;
                            y_q    <= '0;
                            ones_q <= '0;
                            idx_q  <= '0;
                        end
                    end
                end
                SHIFT: begin
                    y_q[idx_q] <= lane_y;
                    ones_q     <= ones_q + CNT_W'(lane_y);
                    idx_q      <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                    sh_a_q     <= sh_a_q >> 1;
                    sh_b_q     <= sh_b_q >> 1;
                    sh_c_q     <= sh_c_q >> 1;
                    sh_d_q     <= sh_d_q >> 1;
                end
                default: begin
                end
            endcase
        end
    end

    // Status flags decode directly from the registered state.
    always_comb begin
        oReady = (state_q == IDLE);
        oBusy  = (state_q == SHIFT);
        oValid = (state_q == HOLD);
        oY     = y_q;
        oOnes  = ones_q;
    end

endmodule

// File: tb/tb_bool_eval_pipe.sv
// Self-checking bench for bool_eval_pipe with WIDTH=8: directed corner cases
// followed by randomized operations checked against a lane-by-lane model.
module tb_bool_eval_pipe;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] a, b, c, d;
    logic             valid_in, mode, ack;
    logic             ready, busy, valid_out;
    logic [WIDTH-1:0] y;
    logic [CNT_W-1:0] ones;

    int vectors = 0;
    int miscompares = 0;

    bool_eval_pipe #(.WIDTH(WIDTH)) dut (
        .iCLK   (clk),
        .iRST_n (rst_n),
        .iA     (a),
        .iB     (b),
        .iC     (c),
        .iD     (d),
        .iValid (valid_in),
        .iMode  (mode),
        .iAck   (ack),
        .oReady (ready),
        .oBusy  (busy),
        .oValid (valid_out),
        .oY     (y),
        .oOnes  (ones)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    // Reference: each lane is 1 when B equals D, or when A equals C and B implies D.
    function automatic logic [WIDTH-1:0] ref_y(input logic [WIDTH-1:0] ra, rb, rc, rd);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = (rb[i] == rd[i]) || ((ra[i] == rc[i]) && (!rb[i] || rd[i]));
        end
        return r;
    endfunction

    function automatic int ref_ones(input logic [WIDTH-1:0] ra, rb, rc, rd);
        return $countones(ref_y(ra, rb, rc, rd));
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] sa, sb, sc, sd,
                                 input logic smode, input logic svalid, input logic sack);
        a        = sa;
        b        = sb;
        c        = sc;
        d        = sd;
        mode     = smode;
        valid_in = svalid;
        ack      = sack;
    endtask

    logic [WIDTH-1:0] ra, rb, rc, rd;
    logic [WIDTH-1:0] pa, pb, pc, pd;
    logic             rmode;
    logic             prev_ready;
    int               lat;
    int               busy_cnt;
    int               hold_cycles;

    initial begin
        rst_n = 1'b0;
        applyStimulus('0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        #12;
        checkOutput("rst_ready", ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_valid", valid_out, 0);
        checkOutput("rst_y", y, 0);
        checkOutput("rst_ones", ones, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // All-zero operands, parallel mode.
        @(negedge clk);
        applyStimulus(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        valid_in = 1'b0;
        checkOutput("zero_valid", valid_out, 1);
        checkOutput("zero_ready", ready, 0);
        checkOutput("zero_y", y, 8'hFF);
        checkOutput("zero_ones", ones, 8);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        checkOutput("zero_ack_ready", ready, 1);

        // Mixed operands, held for three cycles without ack.
        applyStimulus(8'h0F, 8'hCC, 8'h0F, 8'h0A, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        valid_in = 1'b0;
        checkOutput("par_y", y, 8'h3B);
        checkOutput("par_ones", ones, 5);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("par_hold_valid", valid_out, 1);
            checkOutput("par_hold_y", y, 8'h3B);
            checkOutput("par_hold_ones", ones, 5);
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        checkOutput("par_ack_ready", ready, 1);
        checkOutput("par_ack_valid", valid_out, 0);
        checkOutput("par_ack_keep_y", y, 8'h3B);

        // Same operands in serial mode, operands trashed during the walk.
        applyStimulus(8'h0F, 8'hCC, 8'h0F, 8'h0A, 1'b1, 1'b1, 1'b0);
        lat = 0;
        busy_cnt = 0;
        do begin
            @(negedge clk);
            if (lat == 0) applyStimulus(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
            lat++;
            if (busy) busy_cnt++;
            if (busy || valid_out) checkOutput("ser_not_ready", ready, 0);
        end while (!valid_out && lat < 40);
        checkOutput("ser_latency", lat, WIDTH + 1);
        checkOutput("ser_busy_cycles", busy_cnt, WIDTH);
        checkOutput("ser_y", y, 8'h3B);
        checkOutput("ser_ones", ones, 5);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;

        // All-zero result; a request during HOLD must be dropped.
        applyStimulus(8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        valid_in = 1'b0;
        checkOutput("hz_y", y, 8'h00);
        checkOutput("hz_ones", ones, 0);
        applyStimulus(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        valid_in = 1'b0;
        checkOutput("hz_ignored_y", y, 8'h00);
        checkOutput("hz_ignored_valid", valid_out, 1);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        checkOutput("hz_ack_ready", ready, 1);
        @(negedge clk);
        checkOutput("hz_no_second", valid_out, 0);
        checkOutput("hz_idle_ready", ready, 1);

        // Asynchronous reset in the middle of a serial walk.
        applyStimulus(8'h5A, 8'h3C, 8'hA5, 8'hC3, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        valid_in = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_ready", ready, 1);
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_valid", valid_out, 0);
        checkOutput("arst_y", y, 0);
        checkOutput("arst_ones", ones, 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        valid_in = 1'b0;
        checkOutput("arst_first_valid", valid_out, 1);
        checkOutput("arst_first_y", y, 8'hFF);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;

        // Randomized operations in both modes against the reference model.
        for (int n = 0; n < 40; n++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = WIDTH'($urandom);
            rd = WIDTH'($urandom);
            rmode = 1'($urandom_range(0, 1));
            applyStimulus(ra, rb, rc, rd, rmode, 1'b1, 1'b0);
            lat = 0;
            do begin
                @(negedge clk);
                if (lat == 0) applyStimulus(WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom),
                                            WIDTH'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
                lat++;
            end while (!valid_out && lat < 40);
            checkOutput("rnd_latency", lat, rmode ? WIDTH + 1 : 1);
            checkOutput("rnd_y", y, ref_y(ra, rb, rc, rd));
            checkOutput("rnd_ones", ones, ref_ones(ra, rb, rc, rd));
            hold_cycles = $urandom_range(0, 2);
            repeat (hold_cycles) @(negedge clk);
            ack = 1'b1;
            @(negedge clk);
            ack = 1'b0;
            checkOutput("rnd_ack_ready", ready, 1);
        end

        // Back-to-back: request and ack held high together.
        pa = WIDTH'($urandom);
        pb = WIDTH'($urandom);
        pc = WIDTH'($urandom);
        pd = WIDTH'($urandom);
        applyStimulus(pa, pb, pc, pd, 1'b0, 1'b1, 1'b1);
        prev_ready = ready;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checkOutput("b2b_exclusive", ready && valid_out, 0);
            if (prev_ready) begin
                checkOutput("b2b_valid", valid_out, 1);
                checkOutput("b2b_y", y, ref_y(pa, pb, pc, pd));
            end else begin
                checkOutput("b2b_ready", ready, 1);
            end
            prev_ready = ready;
            pa = WIDTH'($urandom);
            pb = WIDTH'($urandom);
            pc = WIDTH'($urandom);
            pd = WIDTH'($urandom);
            applyStimulus(pa, pb, pc, pd, 1'b0, 1'b1, 1'b1);
        end
        applyStimulus('0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
